// File: rtl/vram_arbiter.sv
// Shares one synchronous-read video RAM between display scanout and a CPU port.
// Even visible pixels own the RAM; every other cycle is offered to the CPU FSM.
module vram_arbiter #(
    parameter int H_DISPLAY = 160,
    parameter int V_DISPLAY = 120,
    parameter int ADDR_W    = 14,
    parameter int FB_BYTES  = H_DISPLAY * V_DISPLAY / 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        hpos,
    input  logic [6:0]        vpos,
    input  logic              display_on,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [3:0]        pixel,
    output logic              pixel_valid
);

    // state  | meaning
    // IDLE   | waiting for cpu_req in a CPU slot; grant drives the RAM this cycle
    // ISSUED | RAM read data of the granted access is on mem_rdata
    // ACK    | cpu_ack high for one cycle, no grant possible
    typedef enum logic [1:0] {IDLE, ISSUED, ACK} state_t;

    localparam logic [ADDR_W-1:0] ROW_BYTES = ADDR_W'(H_DISPLAY / 2);
    localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W + 1)'(FB_BYTES);

    state_t            state_q;
    logic              we_q;
    logic              range_q;
    logic              cpu_ack_q;
    logic [7:0]        cpu_rdata_q;

    logic              rd_q;
    logic              hi_q;
    logic [3:0]        hold_q;
    logic              dv1_q;
    logic              dv2_q;
    logic [3:0]        pixel_q;
    logic [3:0]        pixel_d;

    logic              scan_slot;
    logic              in_range;
    logic              grant;
    logic [ADDR_W-1:0] scan_addr;

    assign scan_slot = display_on & ~hpos[0];
    assign in_range  = ({1'b0, cpu_addr} < FB_LIMIT);
    assign grant     = (state_q == IDLE) & cpu_req & ~scan_slot;
    assign scan_addr = ADDR_W'(vpos) * ROW_BYTES + ADDR_W'(hpos[7:1]);

    // Scanout has absolute priority; an out-of-range grant leaves the RAM idle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (scan_slot) begin
            mem_addr = scan_addr;
        end else if (grant && in_range) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we & reset;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            range_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        we_q    <= cpu_we;
                        range_q <= in_range;
                        state_q <= ISSUED;
                    end
                end
                ISSUED: begin
                    cpu_rdata_q <= (we_q || !range_q) ? 8'h00 : mem_rdata;
                    cpu_ack_q   <= 1'b1;
                    state_q     <= ACK;
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Low nibble goes out the cycle after capture, high nibble the cycle after that.
    always_comb begin
        pixel_d = 4'h0;
        if (dv1_q) begin
            if (rd_q)
                pixel_d = mem_rdata[3:0];
            else if (hi_q)
                pixel_d = hold_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= 1'b0;
            hi_q    <= 1'b0;
            hold_q  <= '0;
            dv1_q   <= 1'b0;
            dv2_q   <= 1'b0;
            pixel_q <= '0;
        end else begin
            rd_q    <= scan_slot;
            hi_q    <= rd_q;
            if (rd_q)
                hold_q <= mem_rdata[7:4];
            dv1_q   <= display_on;
            dv2_q   <= dv1_q;
            pixel_q <= pixel_d;
        end
    end

    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign pixel       = pixel_q;
    assign pixel_valid = dv2_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous-read RAM.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  hpos;
    logic [6:0]  vpos;
    logic        display_on;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [3:0]  pixel;
    logic        pixel_valid;

    logic        pre_we;
    logic [13:0] pre_addr;
    logic [7:0]  pre_data;
    logic [7:0]  ram [0:16383];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pixel(pixel), .pixel_valid(pixel_valid)
    );

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beam(input logic [7:0] h, input logic [6:0] v, input logic d);
        hpos = h;
        vpos = v;
        display_on = d;
        #1;
    endtask

    task automatic req(input logic r, input logic w, input logic [13:0] a, input logic [7:0] wd);
        cpu_req = r;
        cpu_we = w;
        cpu_addr = a;
        cpu_wdata = wd;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        pre_we = 1'b1;
        pre_addr = 14'd80;
        pre_data = 8'hA5;
        beam(8'd0, 7'd0, 1'b0);
        req(1'b1, 1'b1, 14'd5, 8'h77);
        step();
        step();
        chk("rst_ack", 16'(cpu_ack), 16'h0);
        chk("rst_rdata", 16'(cpu_rdata), 16'h0);
        chk("rst_pixel", 16'(pixel), 16'h0);
        chk("rst_pvalid", 16'(pixel_valid), 16'h0);
        chk("rst_mem_we", 16'(mem_we), 16'h0);
        pre_we = 1'b0;
        req(1'b0, 1'b0, 14'd0, 8'h00);
        reset = 1'b1;
        step();

        // scanout of byte 80 at (0,1)
        beam(8'd0, 7'd1, 1'b1);
        chk("scan_addr0", 16'(mem_addr), 16'd80);
        chk("scan_we0", 16'(mem_we), 16'h0);
        step();
        beam(8'd1, 7'd1, 1'b1);
        chk("idle_addr", 16'(mem_addr), 16'd0);
        chk("pv_early", 16'(pixel_valid), 16'h0);
        step();
        beam(8'd2, 7'd1, 1'b1);
        chk("scan_addr2", 16'(mem_addr), 16'd81);
        chk("pix_lo", 16'(pixel), 16'h5);
        chk("pv_lo", 16'(pixel_valid), 16'h1);
        step();
        beam(8'd3, 7'd1, 1'b1);
        chk("pix_hi", 16'(pixel), 16'hA);
        chk("pv_hi", 16'(pixel_valid), 16'h1);
        step();

        // CPU write requested in a scan slot waits one cycle
        beam(8'd4, 7'd2, 1'b1);
        req(1'b1, 1'b1, 14'h0123, 8'h3C);
        chk("wr_wait_we", 16'(mem_we), 16'h0);
        chk("wr_wait_addr", 16'(mem_addr), 16'd162);
        step();
        beam(8'd5, 7'd2, 1'b1);
        chk("wr_grant_we", 16'(mem_we), 16'h1);
        chk("wr_grant_addr", 16'(mem_addr), 16'h0123);
        chk("wr_grant_data", 16'(mem_wdata), 16'h3C);
        chk("wr_ack0", 16'(cpu_ack), 16'h0);
        step();
        beam(8'd6, 7'd2, 1'b1);
        chk("wr_scan_addr", 16'(mem_addr), 16'd163);
        chk("wr_scan_we", 16'(mem_we), 16'h0);
        chk("wr_ack1", 16'(cpu_ack), 16'h0);
        step();
        beam(8'd7, 7'd2, 1'b1);
        chk("wr_ack2", 16'(cpu_ack), 16'h1);
        chk("wr_ack_nogrant", 16'(mem_we), 16'h0);
        req(1'b0, 1'b0, 14'd0, 8'h00);
        step();
        beam(8'd8, 7'd2, 1'b1);
        chk("wr_ack_pulse", 16'(cpu_ack), 16'h0);
        step();

        // read-back granted immediately in a CPU slot
        beam(8'd9, 7'd2, 1'b1);
        req(1'b1, 1'b0, 14'h0123, 8'h00);
        chk("rd_grant_addr", 16'(mem_addr), 16'h0123);
        chk("rd_grant_we", 16'(mem_we), 16'h0);
        step();
        beam(8'd10, 7'd2, 1'b1);
        chk("rd_ack1", 16'(cpu_ack), 16'h0);
        step();
        beam(8'd11, 7'd2, 1'b1);
        chk("rd_ack2", 16'(cpu_ack), 16'h1);
        chk("rd_data", 16'(cpu_rdata), 16'h3C);
        req(1'b0, 1'b0, 14'd0, 8'h00);
        step();
        chk("rd_ack_pulse", 16'(cpu_ack), 16'h0);

        // vblank back-to-back reads: grant every third cycle
        beam(8'd0, 7'd120, 1'b0);
        req(1'b1, 1'b0, 14'd80, 8'h00);
        for (int i = 0; i < 9; i++) begin
            chk("vb_grant", 16'(mem_addr), (i % 3 == 0) ? 16'd80 : 16'd0);
            chk("vb_ack", 16'(cpu_ack), (i % 3 == 2) ? 16'h1 : 16'h0);
            if (i % 3 == 2)
                chk("vb_data", 16'(cpu_rdata), 16'hA5);
            step();
        end
        req(1'b0, 1'b0, 14'd0, 8'h00);

        // out-of-range write
        req(1'b1, 1'b1, 14'd9600, 8'hFF);
        chk("oor_we0", 16'(mem_we), 16'h0);
        chk("oor_addr0", 16'(mem_addr), 16'd0);
        step();
        chk("oor_we1", 16'(mem_we), 16'h0);
        chk("oor_ack1", 16'(cpu_ack), 16'h0);
        step();
        chk("oor_ack2", 16'(cpu_ack), 16'h1);
        chk("oor_rdata", 16'(cpu_rdata), 16'h0);
        chk("oor_we2", 16'(mem_we), 16'h0);
        req(1'b0, 1'b0, 14'd0, 8'h00);
        step();

        // last valid byte is still accessed
        req(1'b1, 1'b0, 14'd9599, 8'h00);
        chk("last_addr", 16'(mem_addr), 16'd9599);
        step();
        step();
        chk("last_ack", 16'(cpu_ack), 16'h1);
        req(1'b0, 1'b0, 14'd0, 8'h00);
        step();

        // reset while a CPU read is in ISSUED and pixels are flowing
        beam(8'd0, 7'd1, 1'b1);
        step();
        beam(8'd1, 7'd1, 1'b1);
        req(1'b1, 1'b0, 14'h0123, 8'h00);
        chk("mr_grant", 16'(mem_addr), 16'h0123);
        step();
        beam(8'd2, 7'd1, 1'b1);
        chk("mr_pix_pre", 16'(pixel), 16'h5);
        reset = 1'b0;
        #1;
        chk("mr_ack", 16'(cpu_ack), 16'h0);
        chk("mr_pixel", 16'(pixel), 16'h0);
        chk("mr_pvalid", 16'(pixel_valid), 16'h0);
        chk("mr_rdata", 16'(cpu_rdata), 16'h0);
        step();
        reset = 1'b1;
        beam(8'd3, 7'd1, 1'b0);
        chk("mr_regrant", 16'(mem_addr), 16'h0123);
        step();
        chk("mr_ack1", 16'(cpu_ack), 16'h0);
        step();
        chk("mr_ack2", 16'(cpu_ack), 16'h1);
        chk("mr_data", 16'(cpu_rdata), 16'h3C);
        req(1'b0, 1'b0, 14'd0, 8'h00);
        step();
        chk("mr_ack_pulse", 16'(cpu_ack), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
